// File: rtl/mips_mem_arbiter.sv
// Three-way arbiter (loader, data port, fetch port) in front of a single-port
// word memory; one access in flight, with an anti-starvation guard for fetch.
module mips_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_mode,
  input  logic              ld_req,
  input  logic              dm_req,
  input  logic              if_req,
  input  logic              ld_we,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              ld_gnt,
  output logic              dm_gnt,
  output logic              if_gnt,
  output logic              ld_ack,
  output logic              dm_ack,
  output logic              if_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam int WW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_LD, SRC_DM, SRC_IF} src_t;

  state_t            state;
  src_t              owner;
  src_t              win;
  logic              op_we;
  logic [SW-1:0]     starve_cnt;
  logic [WW-1:0]     wait_cnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Fetch is forced once the data port has taken STARVE_MAX grants in a row
  // while fetch was waiting; otherwise data accesses take precedence.
  always_comb begin
    win       = SRC_NONE;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (state == IDLE) begin
      if (load_mode) begin
        if (ld_req) win = SRC_LD;
      end else if (if_req && starve_cnt == STARVE_LIM) begin
        win = SRC_IF;
      end else if (dm_req) begin
        win = SRC_DM;
      end else if (if_req) begin
        win = SRC_IF;
      end
    end
    case (win)
      SRC_LD: begin
        win_we    = ld_we;
        win_addr  = ld_addr;
        win_wdata = ld_wdata;
      end
      SRC_DM: begin
        win_we    = dm_we;
        win_addr  = dm_addr;
        win_wdata = dm_wdata;
      end
      SRC_IF: win_addr = if_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= SRC_NONE;
      op_we      <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      ld_gnt     <= 1'b0;
      dm_gnt     <= 1'b0;
      if_gnt     <= 1'b0;
      ld_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_ack     <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      ld_gnt <= 1'b0;
      dm_gnt <= 1'b0;
      if_gnt <= 1'b0;
      ld_ack <= 1'b0;
      dm_ack <= 1'b0;
      if_ack <= 1'b0;
      mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (!if_req) starve_cnt <= '0;
          case (win)
            SRC_LD: ld_gnt <= 1'b1;
            SRC_DM: begin
              dm_gnt <= 1'b1;
              if (if_req && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
            end
            SRC_IF: begin
              if_gnt     <= 1'b1;
              starve_cnt <= '0;
            end
            default: ;
          endcase
          if (win != SRC_NONE) begin
            state     <= ISSUE;
            owner     <= win;
            op_we     <= win_we;
            busy      <= 1'b1;
            mem_en    <= 1'b1;
            mem_we    <= win_we;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
          end
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= '0;
          mem_we   <= 1'b0;
        end
        WAIT: begin
          // The final wait cycle is exactly when read data is valid.
          if (wait_cnt == WAIT_LAST) begin
            state <= ACK;
            if (!op_we) rdata <= mem_rdata;
            case (owner)
              SRC_LD:  ld_ack <= 1'b1;
              SRC_DM:  dm_ack <= 1'b1;
              SRC_IF:  if_ack <= 1'b1;
              default: ;
            endcase
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ACK: begin
          state <= IDLE;
          owner <= SRC_NONE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: grant/ack events are logged by a
// monitor and compared in order against expectations queued by each scenario.
module tb_mips_mem_arbiter;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  src;
    logic        en;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_mode;
  logic        ld_req, dm_req, if_req;
  logic        ld_we, dm_we;
  logic [9:0]  ld_addr, dm_addr, if_addr;
  logic [31:0] ld_wdata, dm_wdata;
  logic        ld_gnt, dm_gnt, if_gnt;
  logic        ld_ack, dm_ack, if_ack;
  logic [31:0] rdata;
  logic        busy;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];
  ev_t         obs_q[$];
  int          obs_cyc[$];
  ev_t         exp_q[$];
  int          cyc = 0;
  int          viol = 0;
  logic        prev_en = 1'b0;
  logic [31:0] last_rdata;
  int          total = 0;
  int          bad = 0;

  mips_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .load_mode(load_mode),
    .ld_req(ld_req), .dm_req(dm_req), .if_req(if_req),
    .ld_we(ld_we), .dm_we(dm_we),
    .ld_addr(ld_addr), .dm_addr(dm_addr), .if_addr(if_addr),
    .ld_wdata(ld_wdata), .dm_wdata(dm_wdata),
    .ld_gnt(ld_gnt), .dm_gnt(dm_gnt), .if_gnt(if_gnt),
    .ld_ack(ld_ack), .dm_ack(dm_ack), .if_ack(if_ack),
    .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency synchronous memory
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  function automatic ev_t mk_gnt(input logic [1:0] src, input logic [9:0] addr, input logic en,
                                 input logic we);
    mk_gnt = {2'd1, src, en, we, addr, 32'd0};
  endfunction

  function automatic ev_t mk_ack(input logic [1:0] src, input logic [31:0] data);
    mk_ack = {2'd2, src, 1'b0, 1'b0, 10'd0, data};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (ld_gnt) begin obs_q.push_back(mk_gnt(2'd1, mem_addr, mem_en, mem_we)); obs_cyc.push_back(cyc); end
      if (dm_gnt) begin obs_q.push_back(mk_gnt(2'd2, mem_addr, mem_en, mem_we)); obs_cyc.push_back(cyc); end
      if (if_gnt) begin obs_q.push_back(mk_gnt(2'd3, mem_addr, mem_en, mem_we)); obs_cyc.push_back(cyc); end
      if (ld_ack) begin obs_q.push_back(mk_ack(2'd1, rdata)); obs_cyc.push_back(cyc); end
      if (dm_ack) begin obs_q.push_back(mk_ack(2'd2, rdata)); obs_cyc.push_back(cyc); end
      if (if_ack) begin obs_q.push_back(mk_ack(2'd3, rdata)); obs_cyc.push_back(cyc); end
      if (int'(ld_gnt) + int'(dm_gnt) + int'(if_gnt) > 1) viol++;
      if (int'(ld_ack) + int'(dm_ack) + int'(if_ack) > 1) viol++;
      if (mem_en && prev_en) viol++;
      prev_en = mem_en;
    end else begin
      prev_en = 1'b0;
    end
  end

  task automatic clear_sb();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy_during: got %b need 0", busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({ld_gnt, dm_gnt, if_gnt, ld_ack, dm_ack, if_ack, mem_en, mem_we, mem_addr, mem_wdata, rdata} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %h need 0",
               {ld_gnt, dm_gnt, if_gnt, ld_ack, dm_ack, if_ack, mem_en, mem_we, mem_addr, mem_wdata, rdata});
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b need 0", busy); end
  endtask

  task automatic test_single_read();
    int t0, c_g, c_a;
    ev_t o, e;
    mem[5] = 32'h2842000A;
    @(negedge clk);
    clear_sb();
    t0 = cyc;
    if_req = 1'b1;
    if_addr = 10'h005;
    exp_q.push_back(mk_gnt(2'd3, 10'h005, 1'b1, 1'b0));
    exp_q.push_back(mk_ack(2'd3, 32'h2842000A));
    for (int k = 0; k < 30 && obs_q.size() < exp_q.size(); k++) begin
      @(negedge clk);
      if (if_gnt) if_req = 1'b0;
    end
    if_req = 1'b0;
    last_rdata = 32'h2842000A;
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("[TB] FAIL single_count: got %0d events need %0d", obs_q.size(), exp_q.size());
    end else begin
      c_g = obs_cyc[0];
      c_a = obs_cyc[1];
      total++;
      if (c_g - t0 != 1) begin bad++; $display("[TB] FAIL single_gnt_lat: got %0d need 1", c_g - t0); end
      total++;
      if (c_a - c_g != 2) begin bad++; $display("[TB] FAIL single_ack_lat: got %0d need 2", c_a - c_g); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL single_event: got %h need %h", o, e); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_priority();
    int c_da, c_ig;
    ev_t o, e;
    @(negedge clk);
    clear_sb();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h3FF; dm_wdata = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 10'h3FF;
    exp_q.push_back(mk_gnt(2'd2, 10'h3FF, 1'b1, 1'b1));
    exp_q.push_back(mk_ack(2'd2, last_rdata));
    exp_q.push_back(mk_gnt(2'd3, 10'h3FF, 1'b1, 1'b0));
    exp_q.push_back(mk_ack(2'd3, 32'hDEADBEEF));
    for (int k = 0; k < 40 && obs_q.size() < exp_q.size(); k++) begin
      @(negedge clk);
      if (dm_gnt) dm_req = 1'b0;
      if (if_gnt) if_req = 1'b0;
    end
    dm_req = 1'b0; if_req = 1'b0;
    last_rdata = 32'hDEADBEEF;
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("[TB] FAIL prio_count: got %0d events need %0d", obs_q.size(), exp_q.size());
    end else begin
      c_da = obs_cyc[1];
      c_ig = obs_cyc[2];
      total++;
      if (c_ig - c_da != 2) begin bad++; $display("[TB] FAIL prio_rearb: got %0d need 2", c_ig - c_da); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL prio_event: got %h need %h", o, e); end
    end
    total++;
    if (mem[10'h3FF] !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL prio_memword: got %h need deadbeef", mem[10'h3FF]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_starvation();
    int g;
    ev_t o, e;
    mem[10'h010] = 32'h11111111;
    mem[10'h020] = 32'h22222222;
    @(negedge clk);
    clear_sb();
    g = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h010;
    if_req = 1'b1; if_addr = 10'h020;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin
        exp_q.push_back(mk_gnt(2'd3, 10'h020, 1'b1, 1'b0));
        exp_q.push_back(mk_ack(2'd3, 32'h22222222));
      end else begin
        exp_q.push_back(mk_gnt(2'd2, 10'h010, 1'b1, 1'b0));
        exp_q.push_back(mk_ack(2'd2, 32'h11111111));
      end
    end
    for (int k = 0; k < 100 && obs_q.size() < exp_q.size(); k++) begin
      @(negedge clk);
      if (dm_gnt || if_gnt) g++;
      if (g >= 6) begin dm_req = 1'b0; if_req = 1'b0; end
    end
    dm_req = 1'b0; if_req = 1'b0;
    last_rdata = 32'h11111111;
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("[TB] FAIL starve_count: got %0d events need %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL starve_event: got %h need %h", o, e); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_load_mode();
    int i;
    ev_t o, e;
    @(negedge clk);
    clear_sb();
    i = 0;
    load_mode = 1'b1;
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'h000; ld_wdata = 32'hCAFE0000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h002;
    if_req = 1'b1; if_addr = 10'h001;
    for (int n = 0; n < 4; n++) begin
      exp_q.push_back(mk_gnt(2'd1, 10'(n), 1'b1, 1'b1));
      exp_q.push_back(mk_ack(2'd1, last_rdata));
    end
    exp_q.push_back(mk_gnt(2'd2, 10'h002, 1'b1, 1'b0));
    exp_q.push_back(mk_ack(2'd2, 32'hCAFE0002));
    exp_q.push_back(mk_gnt(2'd3, 10'h001, 1'b1, 1'b0));
    exp_q.push_back(mk_ack(2'd3, 32'hCAFE0001));
    for (int k = 0; k < 100 && obs_q.size() < exp_q.size(); k++) begin
      @(negedge clk);
      if (ld_gnt) begin
        i++;
        if (i < 4) begin
          ld_addr = 10'(i);
          ld_wdata = 32'hCAFE0000 + 32'(i);
        end else begin
          ld_req = 1'b0;
          load_mode = 1'b0;
        end
      end
      if (dm_gnt) dm_req = 1'b0;
      if (if_gnt) if_req = 1'b0;
    end
    ld_req = 1'b0; dm_req = 1'b0; if_req = 1'b0; load_mode = 1'b0;
    last_rdata = 32'hCAFE0001;
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("[TB] FAIL load_count: got %0d events need %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL load_event: got %h need %h", o, e); end
    end
    total++;
    if (mem[3] !== 32'hCAFE0003) begin bad++; $display("[TB] FAIL load_memword: got %h need cafe0003", mem[3]); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int t0, c_g;
    ev_t o, e;
    @(negedge clk);
    clear_sb();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h010;
    exp_q.push_back(mk_gnt(2'd2, 10'h010, 1'b1, 1'b0));
    for (int k = 0; k < 20 && !dm_gnt; k++) @(negedge clk);
    dm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL midrst_busy: got %b need 0", busy); end
    total++;
    if (dm_ack !== 1'b0) begin bad++; $display("[TB] FAIL midrst_ack: got %b need 0", dm_ack); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("[TB] FAIL midrst_count: got %0d events need %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL midrst_event: got %h need %h", o, e); end
    end
    clear_sb();
    t0 = cyc;
    if_req = 1'b1; if_addr = 10'h020;
    exp_q.push_back(mk_gnt(2'd3, 10'h020, 1'b1, 1'b0));
    exp_q.push_back(mk_ack(2'd3, 32'h22222222));
    for (int k = 0; k < 30 && obs_q.size() < exp_q.size(); k++) begin
      @(negedge clk);
      if (if_gnt) if_req = 1'b0;
    end
    if_req = 1'b0;
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("[TB] FAIL postrst_count: got %0d events need %0d", obs_q.size(), exp_q.size());
    end else begin
      c_g = obs_cyc[0];
      total++;
      if (c_g - t0 != 1) begin bad++; $display("[TB] FAIL postrst_gnt_lat: got %0d need 1", c_g - t0); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL postrst_event: got %h need %h", o, e); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_invariants();
    total++;
    if (viol !== 0) begin
      bad++;
      $display("[TB] FAIL invariants: got %0d violations need 0", viol);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load_mode = 1'b0;
    ld_req = 1'b0; dm_req = 1'b0; if_req = 1'b0;
    ld_we = 1'b0; dm_we = 1'b0;
    ld_addr = '0; dm_addr = '0; if_addr = '0;
    ld_wdata = '0; dm_wdata = '0;
    last_rdata = '0;
    for (int a = 0; a < 1024; a++) mem[a] = 32'h0;
    test_reset();
    test_single_read();
    test_priority();
    test_starvation();
    test_load_mode();
    test_reset_midop();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares one single-port 1024x32 word memory between three requesters: program loader (LD), pipeline MEM-stage data port (DM) and pipeline IF-stage fetch port (IF).
- Sits between the pipelined MIPS32 core and the unified instruction/data memory array.
- Serialises accesses with one transaction outstanding at a time. Gives each requester a grant pulse and a completion pulse.
- Prevents fetch starvation under sustained load/store traffic.

Parameters:
- ADDR_W, 10, word-address width (1024 words)
- DATA_W, 32, data width
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata (legal range 1..4)
- STARVE_MAX, 4, max consecutive DM grants while IF is waiting before IF is forced

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_mode  in  1  1 = only LD is eligible; 0 = only DM and IF are eligible
- ld_req, dm_req, if_req  in  1 each  access request
- ld_we, dm_we  in  1 each  1 = write, 0 = read (IF is always read)
- ld_addr, dm_addr, if_addr  in  ADDR_W each  word address
- ld_wdata, dm_wdata  in  DATA_W each  write data
- ld_gnt, dm_gnt, if_gnt  out  1 each  one-cycle pulse: request accepted
- ld_ack, dm_ack, if_ack  out  1 each  one-cycle pulse: access complete
- rdata  out  DATA_W  read data, valid in the ack cycle
- busy  out  1  transaction in flight
- mem_en, mem_we  out  1 each  memory strobe and write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- Reset is asynchronous. Asserting rst_n mid-transaction aborts it: no ack is issued, the FSM returns to IDLE and the starvation counter is cleared.
- States:
  - IDLE: arbitrate.
  - ISSUE: mem_en high for one cycle.
  - WAIT: count MEM_LAT cycles.
  - ACK: pulse ack, then return to IDLE.
- Arbitration (in IDLE, combinational over current req inputs):
  - load_mode=1: winner = LD if ld_req, else none.
  - load_mode=0: winner = IF if if_req and starve_cnt==STARVE_MAX; else DM if dm_req; else IF if if_req; else none.
- On a winner:
  - Capture we/addr/wdata of the winner.
  - Next cycle enter ISSUE: mem_en=1, mem_we/addr/wdata driven from the capture, winner's gnt=1, busy=1.
- Requester handshake:
  - Hold req, we, addr and wdata stable until its gnt.
  - May deassert req, or raise a new request, from the gnt cycle onward.
  - req deasserted before grant = request withdrawn; no error.
- Completion:
  - The ack pulse occurs MEM_LAT+1 cycles after the ISSUE cycle. rdata = mem_rdata sampled MEM_LAT cycles after ISSUE.
  - For writes, ack still pulses; rdata holds its previous value.
- Timing:
  - Latency req (seen in IDLE) -> gnt = 1 cycle. gnt -> ack = MEM_LAT+1 cycles.
  - busy is high from ISSUE through ACK inclusive.
  - Arbitration resumes in the cycle after ACK.
  - Back-to-back throughput = one access per MEM_LAT+3 cycles.
- Starvation counter (starve_cnt, width clog2(STARVE_MAX+1)):
  - Increments on a DM grant while if_req=1.
  - Clears on an IF grant, or whenever if_req=0 in IDLE.
  - Saturates at STARVE_MAX.
- load_mode toggling mid-transaction: the in-flight access completes normally and the new mode applies at the next arbitration.
- Exactly one gnt and one ack may be high in any cycle.
- mem_en is never high in two consecutive cycles.

Test Plan:
- Reset: rst_n low 3 cycles, then high with no req -> all outputs 0, busy=0.
- Single read, MEM_LAT=1: if_req, if_addr=0x005, memory word[5]=0x2842000A -> if_gnt 1 cycle later with mem_addr=0x005 and mem_we=0; if_ack 2 cycles after gnt with rdata=0x2842000A.
- Priority: dm_req (write addr 0x3FF, data 0xDEADBEEF) and if_req raised together -> dm_gnt first and word[0x3FF] written; if_gnt in the first arbitration after dm_ack.
- Starvation: dm_req held continuously plus if_req held, STARVE_MAX=4 -> grant order DM,DM,DM,DM,IF,DM…; no fifth consecutive DM grant.
- Load mode: load_mode=1, ld_req writes 0x000..0x003, dm_req and if_req also high -> only ld_gnt/ld_ack pulses. Drop load_mode -> DM is granted next.
- Reset mid-op: assert rst_n during WAIT of a DM read -> no dm_ack and busy=0 immediately. After release, a fresh if_req completes normally.
